// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with one-hot grant, a bounded hold time and a
// mandatory one-cycle gap between owners.
module rr_arbiter8 #(
    parameter int CNT_W    = 4,
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       E,
    input  logic [7:0] REQ,
    input  logic       REL,
    output logic [7:0] GNT,
    output logic [2:0] GID,
    output logic       VALID,
    output logic       TIMEOUT,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
    localparam logic             HOLD_EN  = (HOLD_MAX != 0);

    state_t           state_q;
    logic [2:0]       gid_q;
    logic [2:0]       ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       gnt_q;
    logic             valid_q;
    logic             timeout_q;

    logic [2:0]       winner;
    logic [2:0]       idx;
    logic             owner_drop;

    function automatic logic [7:0] decode3(input logic [2:0] i);
        decode3 = 8'h01 << i;
    endfunction

    // Scan from ptr+7 down to ptr so the lowest cyclic offset overwrites last and wins.
    always_comb begin
        winner = ptr_q;
        idx    = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr_q + 3'(k);
            if (REQ[idx]) begin
                winner = idx;
            end
        end
    end

    assign owner_drop = !E || REL || !REQ[gid_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gid_q     <= 3'd0;
            ptr_q     <= 3'd0;
            cnt_q     <= '0;
            gnt_q     <= 8'h00;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    timeout_q <= 1'b0;
                    if (E && (REQ != 8'h00)) begin
                        state_q <= S_GRANT;
                        gid_q   <= winner;
                        gnt_q   <= decode3(winner);
                        valid_q <= 1'b1;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                S_GRANT: begin
                    // A voluntary release outranks the hold limit, so TIMEOUT stays low then.
                    if (owner_drop || (HOLD_EN && (cnt_q == HOLD_LIM))) begin
                        state_q   <= S_GAP;
                        gnt_q     <= 8'h00;
                        valid_q   <= 1'b0;
                        cnt_q     <= '0;
                        ptr_q     <= gid_q + 3'd1;
                        timeout_q <= !owner_drop;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    timeout_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    gnt_q     <= 8'h00;
                    valid_q   <= 1'b0;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    assign GNT         = gnt_q;
    assign GID         = gid_q;
    assign VALID       = valid_q;
    assign TIMEOUT     = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed scenario bench for rr_arbiter8 plus a random-request invariant run.
module tb_rr_arbiter8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       E     = 1'b0;
    logic [7:0] REQ   = 8'h00;
    logic       REL   = 1'b0;
    logic [7:0] GNT;
    logic [2:0] GID;
    logic       VALID;
    logic       TIMEOUT;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    rr_arbiter8 #(.CNT_W(4), .HOLD_MAX(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .E          (E),
        .REQ        (REQ),
        .REL        (REL),
        .GNT        (GNT),
        .GID        (GID),
        .VALID      (VALID),
        .TIMEOUT    (TIMEOUT),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        E     = 1'b0;
        REQ   = 8'h00;
        REL   = 1'b0;
        tick();
        rst_n = 1'b1;
        E     = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({GNT, GID, VALID, TIMEOUT, dbg_state} !== {8'h00, 3'd0, 1'b0, 1'b0, 2'd0})
            $display("FAIL reset_state: got gnt=%h gid=%0d v=%b to=%b st=%0d want 00/0/0/0/0",
                     GNT, GID, VALID, TIMEOUT, dbg_state);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        E     = 1'b1;
        REQ   = 8'h00;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({GNT, VALID, TIMEOUT} !== 10'd0)
                $display("FAIL idle_no_req c%0d: got gnt=%h v=%b to=%b want 00/0/0", c, GNT, VALID, TIMEOUT);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        REQ = 8'h10;
        tick();
        n_checks++;
        if ({GNT, GID, VALID} !== {8'h10, 3'd4, 1'b1})
            $display("FAIL pre_reset_grant: got gnt=%h gid=%0d v=%b want 10/4/1", GNT, GID, VALID);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({GNT, VALID} !== 9'd0)
            $display("FAIL async_reset: got gnt=%h v=%b want 00/0", GNT, VALID);
        else n_pass++;
        REQ = 8'h00;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_two_req();
        logic [7:0] exp_g [3] = '{8'h04, 8'h20, 8'h04};
        logic [2:0] exp_id[3] = '{3'd2, 3'd5, 3'd2};
        REQ = 8'h24;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_checks++;
            if ({GNT, GID, VALID} !== {exp_g[j], exp_id[j], 1'b1})
                $display("FAIL two_req_grant%0d: got gnt=%h gid=%0d v=%b want %h/%0d/1",
                         j, GNT, GID, VALID, exp_g[j], exp_id[j]);
            else n_pass++;
            tick();
            tick();
            REL = 1'b1;
            tick();
            REL = 1'b0;
            n_checks++;
            if ({GNT, VALID, GID} !== {8'h00, 1'b0, exp_id[j]})
                $display("FAIL two_req_gap%0d: got gnt=%h v=%b gid=%0d want 00/0/%0d",
                         j, GNT, VALID, GID, exp_id[j]);
            else n_pass++;
            tick();
            n_checks++;
            if (GNT !== 8'h00)
                $display("FAIL two_req_idle%0d: got gnt=%h want 00", j, GNT);
            else n_pass++;
        end
        REQ = 8'h00;
    endtask

    task automatic test_rotate();
        logic [7:0] g;
        do_reset();
        REQ = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            g = 8'h01 << (i % 8);
            tick();
            n_checks++;
            if ({GNT, GID} !== {g, 3'(i % 8)})
                $display("FAIL rotate%0d: got gnt=%h gid=%0d want %h/%0d", i, GNT, GID, g, i % 8);
            else n_pass++;
            tick();
            REL = 1'b1;
            tick();
            REL = 1'b0;
            tick();
        end
        REQ = 8'h00;
    endtask

    task automatic test_timeout();
        do_reset();
        REQ = 8'h08;
        for (int c = 1; c <= 15; c++) begin
            tick();
            n_checks++;
            if ({GNT, GID, VALID, TIMEOUT} !== {8'h08, 3'd3, 1'b1, 1'b0})
                $display("FAIL hold_c%0d: got gnt=%h gid=%0d v=%b to=%b want 08/3/1/0",
                         c, GNT, GID, VALID, TIMEOUT);
            else n_pass++;
        end
        tick();
        n_checks++;
        if ({GNT, VALID, TIMEOUT} !== {8'h00, 1'b0, 1'b1})
            $display("FAIL timeout_pulse: got gnt=%h v=%b to=%b want 00/0/1", GNT, VALID, TIMEOUT);
        else n_pass++;
        tick();
        n_checks++;
        if ({GNT, TIMEOUT} !== 9'd0)
            $display("FAIL timeout_clear: got gnt=%h to=%b want 00/0", GNT, TIMEOUT);
        else n_pass++;
        tick();
        n_checks++;
        if ({GNT, GID, VALID} !== {8'h08, 3'd3, 1'b1})
            $display("FAIL regrant: got gnt=%h gid=%0d v=%b want 08/3/1", GNT, GID, VALID);
        else n_pass++;
        REQ = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_enable_drop();
        do_reset();
        REQ = 8'h40;
        tick();
        n_checks++;
        if ({GNT, GID} !== {8'h40, 3'd6})
            $display("FAIL en_owner6: got gnt=%h gid=%0d want 40/6", GNT, GID);
        else n_pass++;
        E = 1'b0;
        tick();
        n_checks++;
        if ({GNT, VALID, TIMEOUT} !== 10'd0)
            $display("FAIL en_release: got gnt=%h v=%b to=%b want 00/0/0", GNT, VALID, TIMEOUT);
        else n_pass++;
        REQ = 8'h41;
        tick();
        tick();
        tick();
        n_checks++;
        if ({GNT, VALID, GID} !== {8'h00, 1'b0, 3'd6})
            $display("FAIL en_low_hold: got gnt=%h v=%b gid=%0d want 00/0/6", GNT, VALID, GID);
        else n_pass++;
        E = 1'b1;
        tick();
        n_checks++;
        if ({GNT, GID, VALID} !== {8'h01, 3'd0, 1'b1})
            $display("FAIL ptr_wrap: got gnt=%h gid=%0d v=%b want 01/0/1", GNT, GID, VALID);
        else n_pass++;
        REQ = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_rel_timeout();
        do_reset();
        REQ = 8'h08;
        tick();
        repeat (14) tick();
        n_checks++;
        if ({GNT, TIMEOUT} !== {8'h08, 1'b0})
            $display("FAIL rel_to_hold15: got gnt=%h to=%b want 08/0", GNT, TIMEOUT);
        else n_pass++;
        REL = 1'b1;
        tick();
        REL = 1'b0;
        n_checks++;
        if ({GNT, VALID, TIMEOUT} !== 10'd0)
            $display("FAIL rel_wins: got gnt=%h v=%b to=%b want 00/0/0", GNT, VALID, TIMEOUT);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if ({GNT, GID} !== {8'h08, 3'd3})
            $display("FAIL rel_regrant: got gnt=%h gid=%0d want 08/3", GNT, GID);
        else n_pass++;
        REQ = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        REQ = 8'h0C;
        tick();
        n_checks++;
        if ({GNT, GID} !== {8'h04, 3'd2})
            $display("FAIL b2b_first: got gnt=%h gid=%0d want 04/2", GNT, GID);
        else n_pass++;
        REQ = 8'h08;
        tick();
        n_checks++;
        if ({GNT, VALID} !== 9'd0)
            $display("FAIL b2b_drop: got gnt=%h v=%b want 00/0", GNT, VALID);
        else n_pass++;
        REQ = 8'h0C;
        tick();
        n_checks++;
        if (GNT !== 8'h00)
            $display("FAIL b2b_idle: got gnt=%h want 00", GNT);
        else n_pass++;
        tick();
        n_checks++;
        if ({GNT, GID} !== {8'h08, 3'd3})
            $display("FAIL b2b_low_prio: got gnt=%h gid=%0d want 08/3", GNT, GID);
        else n_pass++;
        REL = 1'b1;
        tick();
        REL = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({GNT, GID} !== {8'h04, 3'd2})
            $display("FAIL b2b_wrap_search: got gnt=%h gid=%0d want 04/2", GNT, GID);
        else n_pass++;
        REQ = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [7:0] exp_g;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            REQ = 8'($urandom_range(0, 255));
            E   = ($urandom_range(0, 9) != 0);
            REL = ($urandom_range(0, 7) == 0);
            tick();
            n_checks++;
            if (!$onehot0(GNT))
                $display("FAIL rnd_onehot c%0d: got gnt=%h want one-hot or zero", c, GNT);
            else n_pass++;
            exp_g = VALID ? (8'h01 << GID) : 8'h00;
            n_checks++;
            if (GNT !== exp_g)
                $display("FAIL rnd_decode c%0d: got gnt=%h want %h (v=%b gid=%0d)", c, GNT, exp_g, VALID, GID);
            else n_pass++;
        end
        REQ = 8'h00;
        REL = 1'b0;
        E   = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_two_req();
        test_rotate();
        test_timeout();
        test_enable_drop();
        test_rel_timeout();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one downstream resource between 8 requesters.
- Internally it holds a 3-bit winner index and drives the existing 3-to-8 decoder path, so the grant bus is always one-hot or zero.
- It sits in front of any 8-way shared datapath in the lab designs and sequences ownership with a bounded hold time.

Parameters:
- CNT_W, 4, width of the hold-cycle counter.
- HOLD_MAX, 15, maximum grant cycles before forced release. 0 disables the limit. Must fit in CNT_W bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- E  input  1  arbiter enable, active-high.
- REQ  input  8  request lines; REQ[i] high means requester i wants the resource.
- REL  input  1  voluntary release by the current owner.
- GNT  output  8  one-hot grant; all zero when no owner.
- GID  output  3  index of the current owner; valid only when VALID=1.
- VALID  output  1  high while a grant is active.
- TIMEOUT  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX.

Behaviour:
- Reset is asynchronous on rst_n low, with immediate effect:
  - state=IDLE, GNT=8'h00, GID=3'd0, VALID=0, TIMEOUT=0, ptr=3'd0, hold counter=0.
  - Reset asserted mid-grant drops GNT in the same instant.
- All outputs are registered. GNT equals the decoded GID when VALID=1, else 8'h00. GNT never has more than one bit set.
- State IDLE:
  - Transition occurs when E=1 and REQ!=0 at an edge.
  - Winner = first i with REQ[i]=1, searching cyclically ptr, ptr+1, ..., ptr+7 (mod 8).
  - Next state is GRANT. GID=winner, VALID=1, counter=1.
  - Latency: a request sampled at edge N is granted at edge N, visible after edge N. Effective request-to-grant latency is 1 cycle.
- State GRANT: each edge evaluates the following in priority order.
  1. E=0: release.
  2. REL=1 or REQ[GID]=0: release.
  3. HOLD_MAX!=0 and counter==HOLD_MAX: release with TIMEOUT=1 for exactly the next cycle.
  4. Otherwise hold and counter+1. The counter saturates at its maximum value; it never wraps.
- Release, from any of the cases above:
  - Next state is GAP. VALID=0, GNT=0, counter=0, ptr=GID+1 (mod 8, so 7 wraps to 0). GID keeps the last owner.
- State GAP: exactly one cycle with no grant, TIMEOUT cleared, then IDLE. Requests present during GAP are arbitrated at the IDLE edge. The minimum idle gap between owners is therefore 1 cycle; back-to-back owners are GNT-low for 2 visible cycles.
- Fairness: the previous owner has the lowest priority in the next arbitration. With all 8 requesting, grants rotate 0,1,...,7,0.
- Other requesters changing REQ during GRANT has no effect on the current owner.
- E=0 in IDLE or GAP: no new grant. ptr and GID are held.
- Simultaneous REL and timeout on the same edge: treated as a voluntary release, TIMEOUT=0.
- Owner drops REQ and re-raises it during GAP: it competes at lowest priority.

Test Plan:
- Reset, then REQ=8'h00 with E=1 for 5 cycles -> GNT=8'h00, VALID=0, TIMEOUT=0 throughout. Assert rst_n=0 mid-grant -> GNT=8'h00 without waiting for a clock edge.
- E=1, REQ=8'h24 held, REL pulsed 3 cycles after each grant -> grant order GNT=8'h04 (GID=2), then 8'h20 (GID=5), then 8'h04. One GAP cycle with GNT=0 between owners.
- REQ=8'hFF held, REL pulsed every 2nd grant cycle -> GID sequence 0,1,2,3,4,5,6,7,0 (wrap of ptr from 7 to 0 verified).
- HOLD_MAX=15, REQ=8'h08 held, REL=0 -> GNT=8'h08 for exactly 15 cycles, then TIMEOUT=1 for 1 cycle with GNT=0, then regranted to GID=3 after GAP.
- Owner GID=6 in GRANT, E driven to 0 -> next edge VALID=0, GNT=0, no TIMEOUT. E back to 1 with REQ=8'h41 -> GID=0 granted, since ptr=7 wraps to 0.
- Owner REL and timeout on the same edge (REL asserted at cycle 15) -> release, TIMEOUT stays 0. Separately, on every cycle of a random-REQ run, assert GNT is one-hot or zero and GNT equals the decoded GID when VALID=1.
